store_control: RTL and testbench

//  Write-side counterpart of the load-size path: executes sw/sh/sb stores to data memory.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/store_merge.sv | 32 +++
 rtl/store_control.sv | 94 +++++++++
 tb/tb_store_control.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the store path: store-size encodings, the store FSM
// state type and the alignment rule used to reject stores.
package cpu_pkg;

  typedef enum logic [1:0] {
    SZ_WORD    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_BYTE    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } store_size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } store_state_e;

  // A store is rejected for an illegal size or an address not aligned to its size.
  function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] low_addr);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD:    bad = (low_addr != 2'b00);
      SZ_HALF:    bad = low_addr[0];
      SZ_BYTE:    bad = 1'b0;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane insert: drops the low byte/half of data into the selected
// little-endian lane of the word read back from memory.
module store_merge
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = rdata;
    case (size)
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = data[15:0];
        else         merged[15:0]  = data[15:0];
      end
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      default: merged = data;
    endcase
  end

endmodule

// File: rtl/store_control.sv
// Store sequencer: word stores write directly, half/byte stores read the word,
// merge the new lane in and write it back. Reports Done or AlignErr.
module store_control
  import cpu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  StoreSize,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemRdata,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemWdata,
  output logic        Busy,
  output logic        Done,
  output logic        AlignErr
);

  localparam logic [1:0] LAST_RD = 2'(MEM_RD_LAT - 1);

  store_state_e state_q, state_d;
  logic [31:0]  addr_q;
  logic [31:0]  data_q;
  logic [1:0]   size_q;
  logic [31:0]  wdata_q;
  logic [1:0]   rd_cnt_q;
  logic [31:0]  merged;

  store_merge u_merge (
    .rdata  (MemRdata),
    .data   (data_q),
    .size   (size_q),
    .lane   (addr_q[1:0]),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        addr_q  <= Addr;
        data_q  <= StoreData;
        size_q  <= StoreSize;
        wdata_q <= StoreData;
      end
      if (state_q == READ) rd_cnt_q <= rd_cnt_q + 2'd1;
      else                 rd_cnt_q <= '0;
      // Merged word replaces the latched store data; word stores never pass MERGE.
      if (state_q == MERGE) wdata_q <= merged;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (store_misaligned(StoreSize, Addr[1:0])) state_d = ERR;
          else if (StoreSize == SZ_WORD)              state_d = WRITE;
          else                                        state_d = READ;
        end
      end
      READ:    if (rd_cnt_q == LAST_RD) state_d = MERGE;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the state register only, so reset clears them at once.
  always_comb begin
    MemAddr  = word_align(addr_q);
    MemWr    = (state_q == WRITE);
    MemWdata = '0;
    if (state_q == WRITE) MemWdata = wdata_q;
    Busy     = (state_q != IDLE);
    Done     = (state_q == DONE);
    AlignErr = (state_q == ERR);
  end

endmodule

// File: tb/tb_store_control.sv
// Bench for store_control: three instances (read latency 1..3) share stimulus;
// each has its own memory and a timeline model of the expected outputs.
module tb_store_control;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  StoreSize = 2'd0;
  logic [31:0] Addr = 32'd0;
  logic [31:0] StoreData = 32'd0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s (lat %0d): got %h expected %h", name, lat, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int L = g + 1;
    logic [31:0] rdata, maddr, mwdata;
    logic        mwr, busy, done, aerr;
    logic [31:0] mem    [64];
    logic [31:0] refmem [64];
    logic [5:0]  pipe   [3];

    store_control #(.MEM_RD_LAT(L)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .StoreSize (StoreSize),
      .Addr      (Addr),
      .StoreData (StoreData),
      .MemRdata  (rdata),
      .MemAddr   (maddr),
      .MemWr     (mwr),
      .MemWdata  (mwdata),
      .Busy      (busy),
      .Done      (done),
      .AlignErr  (aerr)
    );

    initial begin
      logic [31:0] v;
      for (int i = 0; i < 64; i++) begin
        v = $urandom;
        mem[i] = v;
        refmem[i] = v;
      end
      mem[16] = 32'h11223344; refmem[16] = 32'h11223344;
      mem[17] = 32'h11223344; refmem[17] = 32'h11223344;
    end

    // Memory as seen by the DUT: read data trails the address by L cycles.
    always @(posedge clk) begin
      if (mwr) mem[maddr[7:2]] = mwdata;
      pipe[0] <= maddr[7:2];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign rdata = mem[pipe[L-1]];

    // Reference model: an accepted store occupies a fixed window of cycles.
    int          n = 0, t0 = 0, kind = 0, len = 0, wd = 0, d = 0;
    bit          active = 1'b0;
    logic [31:0] expAddr, expWdata, old, mask;
    logic [5:0]  idx;
    int          sh;
    logic        eb, ew, ed, ea, ad;

    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        active = 1'b0;
      end else begin
        n++;
        if (active && kind != 2 && n == t0 + wd + 1) refmem[idx] = expWdata;
        if ((!active || n >= t0 + len) && start) begin
          active = 1'b1;
          t0 = n;
          idx = Addr[7:2];
          expAddr = {Addr[31:2], 2'b00};
          if (StoreSize == 2'd3 || (StoreSize == 2'd0 && Addr[1:0] != 2'd0) ||
              (StoreSize == 2'd1 && Addr[0])) begin
            kind = 2; len = 2;
          end else if (StoreSize == 2'd0) begin
            kind = 0; len = 3; wd = 0; expWdata = StoreData;
          end else begin
            kind = 1; len = L + 4; wd = L + 1;
            old = refmem[idx];
            if (StoreSize == 2'd2) begin
              sh = 8 * int'(Addr[1:0]);
              mask = 32'hFF << sh;
            end else begin
              sh = 16 * int'(Addr[1]);
              mask = 32'hFFFF << sh;
            end
            expWdata = (old & ~mask) | ((StoreData << sh) & mask);
          end
        end
      end
    end

    always @(negedge clk) begin
      if (!reset) begin
        check("reset_busy", L, 32'(busy), 32'd0);
        check("reset_memwr", L, 32'(mwr), 32'd0);
        check("reset_done", L, 32'(done), 32'd0);
        check("reset_alignerr", L, 32'(aerr), 32'd0);
        check("reset_memaddr", L, maddr, 32'd0);
        check("reset_memwdata", L, mwdata, 32'd0);
      end else begin
        eb = 0; ew = 0; ed = 0; ea = 0; ad = 0;
        d = n - t0;
        if (active) begin
          if (kind == 2) begin
            if (d == 0) begin eb = 1; ea = 1; end
          end else if (kind == 0) begin
            if (d == 0) begin eb = 1; ew = 1; ad = 1; end
            else if (d == 1) begin eb = 1; ed = 1; end
          end else begin
            if (d <= L + 1) begin eb = 1; ad = 1; ew = (d == L + 1); end
            else if (d == L + 2) begin eb = 1; ed = 1; end
          end
        end
        check("busy", L, 32'(busy), 32'(eb));
        check("memwr", L, 32'(mwr), 32'(ew));
        check("done", L, 32'(done), 32'(ed));
        check("alignerr", L, 32'(aerr), 32'(ea));
        if (ad) check("memaddr", L, maddr, expAddr);
        if (ew) check("memwdata", L, mwdata, expWdata);
        check("done_alignerr_exclusive", L, 32'(done && aerr), 32'd0);
      end
    end
  end

  // Event capture on the latency-1 instance for the directed scenarios.
  int          wrCount = 0, doneCount = 0, errCount = 0, doneCyc = 0, errCyc = 0, startCyc = 0;
  logic [31:0] lastWdata = 32'd0, lastWaddr = 32'd0;

  always @(negedge clk) begin
    if (lane[0].mwr) begin
      wrCount++;
      lastWdata = lane[0].mwdata;
      lastWaddr = lane[0].maddr;
    end
    if (lane[0].done) begin doneCount++; doneCyc = cyc; end
    if (lane[0].aerr) begin errCount++; errCyc = cyc; end
  end

  task automatic clearCounts();
    wrCount = 0; doneCount = 0; errCount = 0;
  endtask

  task automatic applyStimulus(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] dat, input int hold);
    @(posedge clk); #2;
    startCyc = cyc;
    start = 1'b1; StoreSize = sz; Addr = a; StoreData = dat;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
    end
    start = 1'b0;
    StoreSize = 2'($urandom); Addr = $urandom; StoreData = $urandom;
  endtask

  task automatic waitFinish();
    int k;
    k = 0;
    while (doneCount + errCount == 0 && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    check("wait_for_completion", 1, 32'(k < 20), 32'd1);
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int expWr, input logic [31:0] expAddr,
                             input logic [31:0] expData, input int expDone, input int expErr, input int expLat);
    check({name, "_wr_count"}, 1, 32'(wrCount), 32'(expWr));
    check({name, "_done_count"}, 1, 32'(doneCount), 32'(expDone));
    check({name, "_err_count"}, 1, 32'(errCount), 32'(expErr));
    if (expWr > 0) begin
      check({name, "_addr"}, 1, lastWaddr, expAddr);
      check({name, "_wdata"}, 1, lastWdata, expData);
    end
    if (expDone > 0) check({name, "_latency"}, 1, 32'(doneCyc - startCyc + 1), 32'(expLat));
    if (expErr > 0)  check({name, "_latency"}, 1, 32'(errCyc - startCyc + 1), 32'(expLat));
    check({name, "_idle_after"}, 1, 32'(lane[0].busy), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;

    repeat (3) @(posedge clk);
    #2;
    check("reset_state_outputs", 1,
          {26'd0, lane[0].busy, lane[0].mwr, lane[0].done, lane[0].aerr, |lane[0].maddr, |lane[0].mwdata}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    clearCounts(); applyStimulus(2'd2, 32'h42, 32'h000000AB, 1); waitFinish();
    checkOutput("sb_0x42", 1, 32'h40, 32'h11AB3344, 1, 0, 5);
    check("sb_model_mem", 1, lane[0].refmem[16], 32'h11AB3344);
    check("sb_lat3_mem", 3, lane[2].mem[16], 32'h11AB3344);

    clearCounts(); applyStimulus(2'd1, 32'h46, 32'h0000CAFE, 1); waitFinish();
    checkOutput("sh_0x46", 1, 32'h44, 32'hCAFE3344, 1, 0, 5);
    check("sh_model_mem", 1, lane[0].refmem[17], 32'hCAFE3344);
    check("sh_lat2_mem", 2, lane[1].mem[17], 32'hCAFE3344);

    clearCounts(); applyStimulus(2'd0, 32'h40, 32'hDEADBEEF, 1); waitFinish();
    checkOutput("sw_0x40", 1, 32'h40, 32'hDEADBEEF, 1, 0, 3);

    clearCounts(); applyStimulus(2'd0, 32'h41, 32'h01010101, 1); waitFinish();
    checkOutput("sw_misaligned", 0, 32'h0, 32'h0, 0, 1, 2);
    clearCounts(); applyStimulus(2'd1, 32'h43, 32'h02020202, 1); waitFinish();
    checkOutput("sh_misaligned", 0, 32'h0, 32'h0, 0, 1, 2);
    clearCounts(); applyStimulus(2'd3, 32'h40, 32'h03030303, 1); waitFinish();
    checkOutput("size3_illegal", 0, 32'h0, 32'h0, 0, 1, 2);
    check("errors_left_mem", 1, lane[0].mem[16], 32'hDEADBEEF);

    // start held through WRITE and the Done cycle must yield a single store
    clearCounts(); applyStimulus(2'd0, 32'h80, 32'hA5A5F00D, 3); waitFinish();
    checkOutput("start_held", 1, 32'h80, 32'hA5A5F00D, 1, 0, 3);

    clearCounts(); applyStimulus(2'd2, 32'h42, 32'h00000055, 1);
    reset = 1'b0;
    #1;
    check("abort_memwr", 1, 32'(lane[0].mwr), 32'd0);
    check("abort_busy", 1, 32'(lane[0].busy), 32'd0);
    check("abort_memaddr", 1, lane[0].maddr, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("abort_no_write_count", 1, 32'(wrCount), 32'd0);
    check("abort_mem_kept", 3, lane[2].mem[16], 32'hDEADBEEF);
    clearCounts(); applyStimulus(2'd0, 32'h48, 32'h12345678, 1); waitFinish();
    checkOutput("sw_after_abort", 1, 32'h48, 32'h12345678, 1, 0, 3);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd0) a[1:0] = 2'b00;
        else if (sz == 2'd1) a[0] = 1'b0;
      end
      start = ($urandom_range(0, 2) != 0);
      StoreSize = sz;
      Addr = a;
      StoreData = $urandom;
    end
    @(posedge clk); #2;
    start = 1'b0;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
